// File: rtl/conv_window_kxk.sv
// rtl/conv_window_kxk.sv - streaming KxK two-kernel convolution with valid-only borders
// Window is formed from K-1 full-line buffers plus a KxK register array; the result is
// computed from the post-accept window so the output register loads on the accepting edge.
module conv_window_kxk #(
  parameter int linewidth_px_p    = 16,
  parameter int frame_height_px_p = 16,
  parameter int kernel_p          = 3,
  parameter int in_width_p        = 8,
  parameter int weight_width_p    = 4,
  parameter int out_width_p       = 16
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic                                             valid_i,
  output logic                                             ready_o,
  input  logic [in_width_p-1:0]                            data_i,
  input  logic                                             mode_i,
  input  logic [kernel_p*kernel_p*weight_width_p-1:0]      weights_x_i,
  input  logic [kernel_p*kernel_p*weight_width_p-1:0]      weights_y_i,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic signed [out_width_p-1:0]                    data_o,
  output logic                                             last_o
);
  localparam int K  = kernel_p;
  localparam int W  = linewidth_px_p;
  localparam int H  = frame_height_px_p;
  localparam int IW = in_width_p;
  localparam int WW = weight_width_p;
  localparam int OW = out_width_p;
  localparam int SW = IW + WW + $clog2(K*K) + 1;
  localparam int CW = ((SW > OW) ? SW : OW) + 2;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int NW = K*K*WW;
  localparam logic signed [CW-1:0] SAT_HI = CW'((longint'(1) <<< (OW-1)) - 1);
  localparam logic signed [CW-1:0] SAT_LO = CW'(-(longint'(1) <<< (OW-1)));

  logic [XW-1:0]        r_col;
  logic [YW-1:0]        r_row;
  logic [IW-1:0]        r_win [K][K];
  logic [IW-1:0]        r_lb  [K-1][W];
  logic [NW-1:0]        r_wx;
  logic [NW-1:0]        r_wy;
  logic                 r_mode;
  logic                 r_valid;
  logic                 r_last;
  logic signed [OW-1:0] r_data;

  logic                 w_accept;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_first;
  logic                 w_emit;
  logic [IW-1:0]        w_newcol [K];
  logic [IW-1:0]        w_nwin   [K][K];
  logic signed [SW-1:0] w_px;
  logic signed [SW-1:0] w_wxe;
  logic signed [SW-1:0] w_wye;
  logic signed [SW-1:0] w_sum_x;
  logic signed [SW-1:0] w_sum_y;
  logic signed [CW-1:0] w_x_ext;
  logic signed [CW-1:0] w_y_ext;
  logic signed [CW-1:0] w_ax;
  logic signed [CW-1:0] w_ay;
  logic signed [CW-1:0] w_mag;
  logic signed [OW-1:0] w_out;

  assign ready_o    = ~r_valid | ready_i;
  assign w_accept   = valid_i & ready_o;
  assign w_col_last = (r_col == XW'(W-1));
  assign w_row_last = (r_row == YW'(H-1));
  assign w_first    = (r_col == '0) && (r_row == '0);
  assign w_emit     = (r_col >= XW'(K-1)) && (r_row >= YW'(K-1));

  // Line buffer j holds row y-1-j, so it feeds window row K-2-j.
  always_comb begin
    w_newcol[K-1] = data_i;
    for (int r = 0; r < K-1; r++) w_newcol[r] = r_lb[K-2-r][r_col];
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) w_nwin[r][c] = r_win[r][c+1];
      w_nwin[r][K-1] = w_newcol[r];
    end
  end

  always_comb begin
    w_sum_x = '0;
    w_sum_y = '0;
    w_px    = '0;
    w_wxe   = '0;
    w_wye   = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_px    = {{(SW-IW){1'b0}}, w_nwin[r][c]};
        w_wxe   = {{(SW-WW){r_wx[(r*K+c)*WW+WW-1]}}, r_wx[(r*K+c)*WW +: WW]};
        w_wye   = {{(SW-WW){r_wy[(r*K+c)*WW+WW-1]}}, r_wy[(r*K+c)*WW +: WW]};
        w_sum_x = w_sum_x + w_px * w_wxe;
        w_sum_y = w_sum_y + w_px * w_wye;
      end
    end
  end

  always_comb begin
    w_x_ext = {{(CW-SW){w_sum_x[SW-1]}}, w_sum_x};
    w_y_ext = {{(CW-SW){w_sum_y[SW-1]}}, w_sum_y};
    w_ax    = (w_x_ext < 0) ? -w_x_ext : w_x_ext;
    w_ay    = (w_y_ext < 0) ? -w_y_ext : w_y_ext;
    w_mag   = w_ax + w_ay;
    w_out   = '0;
    if (r_mode) w_out = (w_mag > SAT_HI) ? OW'(SAT_HI) : OW'(w_mag);
    else if (w_x_ext > SAT_HI) w_out = OW'(SAT_HI);
    else if (w_x_ext < SAT_LO) w_out = OW'(SAT_LO);
    else w_out = OW'(w_x_ext);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_col   <= '0;
      r_row   <= '0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
    end else begin
      if (w_accept) begin
        r_win   <= w_nwin;
        r_col   <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
        if (w_first) begin
          r_mode <= mode_i;
          r_wx   <= weights_x_i;
          r_wy   <= weights_y_i;
        end
        r_valid <= w_emit;
        r_last  <= w_emit & w_col_last & w_row_last;
        if (w_emit) r_data <= w_out;
      end else if (ready_i) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  // Line-buffer storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb[0][r_col] <= data_i;
      for (int j = 1; j < K-1; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign last_o  = r_last;
endmodule

// File: tb/tb_conv_window_kxk.sv
// tb/tb_conv_window_kxk.sv - self-checking bench for conv_window_kxk
module tb_conv_window_kxk;
  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        mode_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [7:0]  data_i = '0;
  logic [35:0] wx_v = '0;
  logic [35:0] wy_v = '0;
  logic        ready_o16, valid_o16, last_o16;
  logic [15:0] data_o16;
  logic        ready_o8, valid_o8, last_o8;
  logic [7:0]  data_o8;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int gap_pct = 0;
  int img [H*W];
  int wx [9];
  int wy [9];
  int q16_d[$], q8_d[$], e16_d[$], e8_d[$];
  bit q16_l[$], q8_l[$], e16_l[$], e8_l[$];
  bit          st_pend = 1'b0;
  logic [15:0] st_d;
  logic        st_l;

  conv_window_kxk #(.linewidth_px_p(W), .frame_height_px_p(H), .kernel_p(K),
                    .in_width_p(8), .weight_width_p(4), .out_width_p(16)) dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(ready_o16),
    .data_i(data_i), .mode_i(mode_i), .weights_x_i(wx_v), .weights_y_i(wy_v),
    .valid_o(valid_o16), .ready_i(ready_i), .data_o(data_o16), .last_o(last_o16));

  conv_window_kxk #(.linewidth_px_p(W), .frame_height_px_p(H), .kernel_p(K),
                    .in_width_p(8), .weight_width_p(4), .out_width_p(8)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(ready_o8),
    .data_i(data_i), .mode_i(mode_i), .weights_x_i(wx_v), .weights_y_i(wy_v),
    .valid_o(valid_o8), .ready_i(ready_i), .data_o(data_o8), .last_o(last_o8));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Transfers are recorded at negedge; they complete on the following posedge.
  always @(negedge clk) begin
    if (valid_o16 && ready_i) begin
      q16_d.push_back(int'($signed(data_o16)));
      q16_l.push_back(last_o16);
    end
    if (valid_o8 && ready_i) begin
      q8_d.push_back(int'($signed(data_o8)));
      q8_l.push_back(last_o8);
    end
    if (st_pend && reset_n) begin
      checks++;
      if (valid_o16 !== 1'b1 || data_o16 !== st_d || last_o16 !== st_l) begin
        failures++;
        $display("FAIL stall_hold got v=%0b d=%0d l=%0b exp v=1 d=%0d l=%0b",
                 valid_o16, data_o16, last_o16, st_d, st_l);
      end
    end
    st_pend = valid_o16 && !ready_i && reset_n;
    st_d    = data_o16;
    st_l    = last_o16;
  end

  function automatic logic [35:0] pack(input int a [9]);
    logic [35:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[i*4 +: 4] = 4'(a[i]);
    return p;
  endfunction

  function automatic int sat(input longint sx, input longint sy, input int mode, input int ow);
    longint hi, lo, v;
    hi = (longint'(1) << (ow-1)) - 1;
    lo = -hi - 1;
    if (mode != 0) begin
      v = ((sx < 0) ? -sx : sx) + ((sy < 0) ? -sy : sy);
      if (v > hi) v = hi;
    end else begin
      v = sx;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
    end
    return int'(v);
  endfunction

  task automatic model_frame(input int mode);
    longint sx, sy;
    int p;
    for (int y = K-1; y < H; y++) begin
      for (int x = K-1; x < W; x++) begin
        sx = 0;
        sy = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            p = img[(y-K+1+r)*W + (x-K+1+c)];
            sx += p * wx[r*K+c];
            sy += p * wy[r*K+c];
          end
        e16_d.push_back(sat(sx, sy, mode, 16));
        e16_l.push_back(x == W-1 && y == H-1);
        e8_d.push_back(sat(sx, sy, mode, 8));
        e8_l.push_back(x == W-1 && y == H-1);
      end
    end
  endtask

  task automatic send_pixel(input int d, input int m, input logic [35:0] xv, input logic [35:0] yv);
    int n;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b1;
    data_i  = 8'(d);
    mode_i  = m[0];
    wx_v    = xv;
    wy_v    = yv;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_o16) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 1000) begin
        failures++;
        $display("FAIL accept_timeout got=stalled exp=accept");
        break;
      end
    end
  endtask

  // Pixels from index sw on carry mode m_b and garbage weights; the latched frame values must win.
  task automatic send_frame(input int m_a, input int m_b, input int sw, input int n_px);
    logic [35:0] px, py, gx, gy;
    px = pack(wx);
    py = pack(wy);
    for (int i = 0; i < n_px; i++) begin
      gx = 36'({$urandom(), $urandom()});
      gy = 36'({$urandom(), $urandom()});
      if (i < sw) send_pixel(img[i], m_a, px, py);
      else        send_pixel(img[i], m_b, gx, gy);
    end
    valid_i = 1'b0;
  endtask

  task automatic check_outputs(input string name);
    int n;
    n = 0;
    while ((q16_d.size() < e16_d.size() || q8_d.size() < e8_d.size()) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q16_d.size() != e16_d.size()) begin
      failures++;
      $display("FAIL %s count16 got=%0d exp=%0d", name, q16_d.size(), e16_d.size());
    end
    checks++;
    if (q8_d.size() != e8_d.size()) begin
      failures++;
      $display("FAIL %s count8 got=%0d exp=%0d", name, q8_d.size(), e8_d.size());
    end
    for (int i = 0; i < e16_d.size() && i < q16_d.size(); i++) begin
      checks++;
      if (q16_d[i] !== e16_d[i] || q16_l[i] !== e16_l[i]) begin
        failures++;
        $display("FAIL %s out16[%0d] got d=%0d l=%0b exp d=%0d l=%0b",
                 name, i, q16_d[i], q16_l[i], e16_d[i], e16_l[i]);
      end
    end
    for (int i = 0; i < e8_d.size() && i < q8_d.size(); i++) begin
      checks++;
      if (q8_d[i] !== e8_d[i] || q8_l[i] !== e8_l[i]) begin
        failures++;
        $display("FAIL %s out8[%0d] got d=%0d l=%0b exp d=%0d l=%0b",
                 name, i, q8_d[i], q8_l[i], e8_d[i], e8_l[i]);
      end
    end
    q16_d.delete(); q16_l.delete(); q8_d.delete(); q8_l.delete();
    e16_d.delete(); e16_l.delete(); e8_d.delete(); e8_l.delete();
  endtask

  task automatic load_sobel();
    int sxk [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int syk [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    wx = sxk;
    wy = syk;
  endtask

  task automatic load_random_weights();
    for (int i = 0; i < 9; i++) begin
      wx[i] = int'($urandom_range(0, 15)) - 8;
      wy[i] = int'($urandom_range(0, 15)) - 8;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_o16 !== 1'b0 || data_o16 !== 16'd0 || last_o16 !== 1'b0 || ready_o16 !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%0b d=%0d l=%0b r=%0b exp v=0 d=0 l=0 r=1",
               valid_o16, data_o16, last_o16, ready_o16);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_constant();
    load_sobel();
    for (int i = 0; i < H*W; i++) img[i] = 10;
    model_frame(0);
    send_frame(0, 0, H*W, H*W);
    check_outputs("constant");
  endtask

  task automatic test_ramps();
    load_sobel();
    for (int i = 0; i < H*W; i++) img[i] = i % W;
    model_frame(0);
    send_frame(0, 0, H*W, H*W);
    check_outputs("ramp_x");
    for (int i = 0; i < H*W; i++) img[i] = i / W;
    model_frame(1);
    send_frame(1, 1, H*W, H*W);
    check_outputs("ramp_y");
  endtask

  task automatic test_saturation();
    load_sobel();
    for (int i = 0; i < H*W; i++) img[i] = ((i % W) >= 3 && (i % W) <= 4) ? 255 : 0;
    model_frame(0);
    send_frame(0, 0, H*W, H*W);
    check_outputs("sat_mode0");
    model_frame(1);
    send_frame(1, 1, H*W, H*W);
    check_outputs("sat_mode1");
  endtask

  task automatic test_random_stall();
    rdy_mode = 1;
    gap_pct  = 30;
    for (int f = 0; f < 3; f++) begin
      int m;
      m = int'($urandom_range(0, 1));
      load_random_weights();
      for (int i = 0; i < H*W; i++) img[i] = int'($urandom_range(0, 255));
      model_frame(m);
      send_frame(m, 1 - m, 1, H*W);
    end
    check_outputs("random_stall");
    rdy_mode = 0;
    gap_pct  = 0;
  endtask

  task automatic test_reset_midframe();
    load_random_weights();
    for (int i = 0; i < H*W; i++) img[i] = int'($urandom_range(0, 255));
    send_frame(0, 0, H*W, 20);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_o16 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid got=%0b exp=1", valid_o16);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o16 !== 1'b0 || ready_o16 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got v=%0b r=%0b exp v=0 r=1", valid_o16, ready_o16);
    end
    q16_d.delete(); q16_l.delete(); q8_d.delete(); q8_l.delete();
    @(posedge clk);
    #1;
    load_random_weights();
    for (int i = 0; i < H*W; i++) img[i] = int'($urandom_range(0, 255));
    model_frame(0);
    send_frame(0, 0, H*W, H*W);
    check_outputs("after_reset");
  endtask

  task automatic test_back_to_back();
    load_random_weights();
    for (int i = 0; i < H*W; i++) img[i] = int'($urandom_range(0, 255));
    model_frame(0);
    send_frame(0, 1, 24, H*W);
    load_random_weights();
    for (int i = 0; i < H*W; i++) img[i] = int'($urandom_range(0, 255));
    model_frame(1);
    send_frame(1, 1, H*W, H*W);
    check_outputs("back_to_back");
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramps();
    test_saturation();
    test_random_stall();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
